boot_loader: RTL
================

Name: boot_loader

Overview:
- Parametrised successor to the fixed one-cycle program-load phase in the top-level.
- Receives a byte-serial program image, packs bytes into words, and writes every word to data memory.
- Packs the same words into FETCH_WIDTH-word instruction-memory lines.
- Holds the core in reset until loading finishes, then hands both memory ports to the core through an internal address/data mux.

Parameters:
- DATA_LEN, 32: word width; fixed at 32 for byte assembly.
- ADDR_LEN, 32: core byte-address width.
- FETCH_WIDTH, 4: words per imem line; must be a power of 2, range 1..8.
- IMEM_AW, 9: imem line-address width.
- MAX_WORDS, 2048: largest accepted image, in words.
- HOLD_CYCLES, 4: cycles core_reset stays high after the last write.

Ports:
- clk  in  1  clock
- reset_x  in  1  synchronous active-low reset
- rx_valid  in  1  byte available
- rx_data  in  8  byte, little-endian within each word
- rx_ready  out  1  byte accepted when rx_valid&&rx_ready
- core_reset  out  1  reset to pipeline
- prog_loading  out  1  load phase active
- load_done  out  1  sticky; image fully written
- load_err  out  1  sticky; length > MAX_WORDS
- core_pc  in  ADDR_LEN  core fetch PC
- core_dmem_addr  in  ADDR_LEN  core data address
- core_dmem_wdata  in  DATA_LEN  core store data
- core_dmem_we  in  1  core store enable
- imem_addr  out  IMEM_AW  muxed line address
- imem_wdata  out  FETCH_WIDTH*DATA_LEN  load line
- imem_we  out  1  line write pulse
- dmem_addr  out  ADDR_LEN  muxed byte address
- dmem_wdata  out  DATA_LEN  muxed write data
- dmem_we  out  1  muxed write enable

Behaviour:
- Reset (reset_x=0 at clk edge):
  - state=HDR; all counters clear.
  - Outputs: rx_ready=0, core_reset=1, prog_loading=1, load_done=0, load_err=0, imem_we=0, loader dmem_we=0.
- States: HDR, DATA, FLUSH, HOLD, RUN, ERR.
- rx_ready=1 only in HDR and DATA. One byte per cycle maximum.
- HDR:
  - Collect 4 bytes into length N (byte 0 = LSB).
  - On the 4th byte: if N>MAX_WORDS go to ERR; if N==0 go to HOLD; otherwise go to DATA.
- DATA:
  - Every 4 bytes form word i, for i = 0..N-1.
  - The cycle after the 4th byte is accepted: dmem_we=1, dmem_addr=4*i, dmem_wdata=word (one-cycle pulse).
  - Word goes into line slot k = i mod FETCH_WIDTH. Slot 0 occupies the MS bits: [(FETCH_WIDTH-k)*32-1 -: 32].
  - When k==FETCH_WIDTH-1: imem_we=1 in the same cycle as that word's dmem_we; imem_addr=i/FETCH_WIDTH; line buffer clears.
  - After word N-1: go to FLUSH if the line is partial, otherwise go to HOLD.
- FLUSH:
  - One cycle of imem_we with unfilled slots zero.
  - Then go to HOLD.
- HOLD:
  - load_done=1 from entry.
  - Count HOLD_CYCLES, then go to RUN.
- RUN:
  - prog_loading=0, core_reset=0.
  - Terminal until reset.
- ERR:
  - load_err=1, rx_ready=0, core held in reset.
  - Terminal until reset.
- Mux (combinational on prog_loading):
  - Loading: memory ports carry loader values; core_dmem_we is ignored.
  - Not loading:
    - dmem_addr/wdata/we pass core values.
    - imem_addr = core_pc[IMEM_AW+LB-1:LB], where LB=log2(FETCH_WIDTH*4).
    - imem_we=0.
- Byte/word counters are ADDR_LEN wide; the line address wraps modulo 2^IMEM_AW with no error.
- rx_valid low mid-word stalls assembly indefinitely; partial bytes are retained.
- Reset mid-load discards everything and restarts at HDR.
- In RUN/ERR, rx bytes are ignored.

Decomposition:
- Shared package holds:
  - Byte/word/line width constants.
  - State encoding: HDR=0, DATA=1, FLUSH=2, HOLD=3, RUN=4, ERR=5.
  - The LB log2 helper.
- One sub-module: boot_word_packer. It assembles bytes to words and words to lines, and emits word_valid/line_valid.
- The FSM, hold counter and mux stay in boot_loader.

Test Plan:
- Stream len=8 plus 8 words 0x11111111..0x88888888 (FETCH_WIDTH=4) -> 8 dmem writes at 0x0..0x1C; imem_we at line 0 = {0x11111111,...,0x44444444} and line 1; core_reset falls 4 cycles after load_done.
- len=5 -> imem line 1 = {0x55555555,0,0,0} written in FLUSH; dmem writes at 0x0..0x10.
- len=0 -> no memory writes; load_done next cycle; RUN after HOLD_CYCLES.
- len=MAX_WORDS+1 -> load_err=1; rx_ready=0; core_reset stays 1 for 100 cycles.
- Random rx_valid gaps, plus reset_x=0 after 3 data words then a fresh len=4 image -> only the new image's words are written; counters restart at address 0.
- In RUN, core_dmem_we=1, addr=0x40, core_pc=0x120 -> dmem_we=1 at 0x40; imem_addr=0x12; imem_we=0.

Source files
------------

// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg
// Shared constants, FSM state encoding and a log2 helper for the boot loader
// slice. Imported by the interface, the word packer and the top level.
package boot_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = BYTE_W * WORD_BYTES;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_HOLD  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Smallest r with 2**r >= value; used for slot and line-offset widths.
    function automatic int log2Int(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if
// Bundles the byte stream, status flags, core-side memory requests and the
// muxed memory ports of the boot loader.
//   master : boot loader view (consumes rx/core requests, drives memories)
//   slave  : environment view (drives rx/core requests, observes memories)
interface boot_loader_if
    import boot_loader_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int IMEM_AW     = 9
);

    logic                          rx_valid;
    logic [BYTE_W-1:0]             rx_data;
    logic                          rx_ready;

    logic                          core_reset;
    logic                          prog_loading;
    logic                          load_done;
    logic                          load_err;

    logic [ADDR_LEN-1:0]           core_pc;
    logic [ADDR_LEN-1:0]           core_dmem_addr;
    logic [DATA_LEN-1:0]           core_dmem_wdata;
    logic                          core_dmem_we;

    logic [IMEM_AW-1:0]            imem_addr;
    logic [FETCH_WIDTH*DATA_LEN-1:0] imem_wdata;
    logic                          imem_we;

    logic [ADDR_LEN-1:0]           dmem_addr;
    logic [DATA_LEN-1:0]           dmem_wdata;
    logic                          dmem_we;

    modport master (
        input  rx_valid, rx_data, core_pc, core_dmem_addr, core_dmem_wdata, core_dmem_we,
        output rx_ready, core_reset, prog_loading, load_done, load_err,
               imem_addr, imem_wdata, imem_we, dmem_addr, dmem_wdata, dmem_we
    );

    modport slave (
        output rx_valid, rx_data, core_pc, core_dmem_addr, core_dmem_wdata, core_dmem_we,
        input  rx_ready, core_reset, prog_loading, load_done, load_err,
               imem_addr, imem_wdata, imem_we, dmem_addr, dmem_wdata, dmem_we
    );

endinterface

// File: rtl/boot_word_packer.sv
// boot_word_packer
// Assembles little-endian bytes into words and words into FETCH_WIDTH-word
// instruction lines (slot 0 in the most significant bits).
// Ports:
//   byte_valid_i/byte_i : accepted image byte
//   last_word_i         : the word being completed is the final one
//   word_done_o         : this cycle completes a word (combinational)
//   slot_full_o         : the word in progress fills the last line slot
//   word_idx_o          : index of the word in progress
//   word_valid_o/word_o/word_addr_o : registered one-cycle data-memory write
//   line_valid_o/line_o/line_addr_o : registered one-cycle imem line write
module boot_word_packer
    import boot_loader_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int IMEM_AW     = 9
) (
    input  logic                            clk,
    input  logic                            reset_x,
    input  logic                            byte_valid_i,
    input  logic [BYTE_W-1:0]               byte_i,
    input  logic                            last_word_i,
    output logic                            word_done_o,
    output logic                            slot_full_o,
    output logic [ADDR_LEN-1:0]             word_idx_o,
    output logic                            word_valid_o,
    output logic [DATA_LEN-1:0]             word_o,
    output logic [ADDR_LEN-1:0]             word_addr_o,
    output logic                            line_valid_o,
    output logic [FETCH_WIDTH*DATA_LEN-1:0] line_o,
    output logic [IMEM_AW-1:0]              line_addr_o
);

    localparam int SLOT_BITS = log2Int(FETCH_WIDTH);
    localparam int LINE_W    = FETCH_WIDTH * DATA_LEN;

    logic [1:0]                 byteCnt_q;
    logic [DATA_LEN-BYTE_W-1:0] wordBuf_q;
    logic [ADDR_LEN-1:0]        wordCnt_q;
    logic [LINE_W-1:0]          lineBuf_q;
    logic                       wordValid_q;
    logic [DATA_LEN-1:0]        word_q;
    logic [ADDR_LEN-1:0]        wordAddr_q;
    logic                       lineValid_q;
    logic [LINE_W-1:0]          line_q;
    logic [IMEM_AW-1:0]         lineAddr_q;

    logic [DATA_LEN-1:0]        fullWord;
    logic [ADDR_LEN-1:0]        slotIdx;
    logic [LINE_W-1:0]          lineNext;

    // The fourth byte of a word is the most significant one.
    assign fullWord    = {byte_i, wordBuf_q};
    assign slotIdx     = wordCnt_q & ADDR_LEN'(FETCH_WIDTH - 1);
    assign word_done_o = byte_valid_i && (byteCnt_q == 2'd3);
    assign slot_full_o = (slotIdx == ADDR_LEN'(FETCH_WIDTH - 1));
    assign word_idx_o  = wordCnt_q;

    // Line buffer with the completing word dropped into its slot.
    always_comb begin
        lineNext = lineBuf_q;
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (slotIdx == ADDR_LEN'(k)) begin
                lineNext[(FETCH_WIDTH-k)*DATA_LEN-1 -: DATA_LEN] = fullWord;
            end
        end
    end

    // Byte/word assembly. A line is emitted when its last slot fills or when
    // the final word of the image lands, so a partial line carries zeros in
    // its unfilled slots. The buffer clears after every emitted line.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            byteCnt_q   <= 2'd0;
            wordBuf_q   <= '0;
            wordCnt_q   <= '0;
            lineBuf_q   <= '0;
            wordValid_q <= 1'b0;
            word_q      <= '0;
            wordAddr_q  <= '0;
            lineValid_q <= 1'b0;
            line_q      <= '0;
            lineAddr_q  <= '0;
        end else begin
            wordValid_q <= 1'b0;
            lineValid_q <= 1'b0;
            if (byte_valid_i) begin
                case (byteCnt_q)
                    2'd0: wordBuf_q[7:0]   <= byte_i;
                    2'd1: wordBuf_q[15:8]  <= byte_i;
                    2'd2: wordBuf_q[23:16] <= byte_i;
                    default: begin
                        wordValid_q <= 1'b1;
                        word_q      <= fullWord;
                        wordAddr_q  <= {wordCnt_q[ADDR_LEN-3:0], 2'b00};
                        wordCnt_q   <= wordCnt_q + 1'b1;
                        if (slot_full_o || last_word_i) begin
                            lineValid_q <= 1'b1;
                            line_q      <= lineNext;
                            lineAddr_q  <= IMEM_AW'(wordCnt_q >> SLOT_BITS);
                            lineBuf_q   <= '0;
                        end else begin
                            lineBuf_q   <= lineNext;
                        end
                    end
                endcase
                byteCnt_q <= byteCnt_q + 2'd1;
            end
        end
    end

    assign word_valid_o = wordValid_q;
    assign word_o       = word_q;
    assign word_addr_o  = wordAddr_q;
    assign line_valid_o = lineValid_q;
    assign line_o       = line_q;
    assign line_addr_o  = lineAddr_q;

endmodule

// File: rtl/boot_loader.sv
// boot_loader
// Loads a byte-serial program image (4-byte length header, then N words)
// into data and instruction memory, holds the core in reset until done, then
// hands both memory ports to the core.
// Ports:
//   clk, reset_x : clock, synchronous active-low reset
//   bus (master) : rx byte stream, status flags, core requests, memory ports
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int DATA_LEN    = 32,
    parameter int ADDR_LEN    = 32,
    parameter int FETCH_WIDTH = 4,
    parameter int IMEM_AW     = 9,
    parameter int MAX_WORDS   = 2048,
    parameter int HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset_x,
    boot_loader_if.master bus
);

    localparam int LB = log2Int(FETCH_WIDTH * WORD_BYTES);

    state_t                          state_q;
    logic [1:0]                      hdrCnt_q;
    logic [31:0]                     len_q;
    logic [15:0]                     holdCnt_q;
    logic                            rxReady_q;
    logic                            coreReset_q;
    logic                            progLoading_q;
    logic                            loadDone_q;
    logic                            loadErr_q;

    logic                            accept;
    logic                            dataByte;
    logic [31:0]                     hdrLen;
    logic                            lastWord;
    logic                            wordDone;
    logic                            slotFull;
    logic [ADDR_LEN-1:0]             wordIdx;
    logic                            wordValid;
    logic [DATA_LEN-1:0]             wordData;
    logic [ADDR_LEN-1:0]             wordAddr;
    logic                            lineValid;
    logic [FETCH_WIDTH*DATA_LEN-1:0] lineData;
    logic [IMEM_AW-1:0]              lineAddr;
    logic                            unusedPc;

    assign accept   = bus.rx_valid && rxReady_q;
    assign dataByte = accept && (state_q == ST_DATA);
    assign hdrLen   = {bus.rx_data, len_q[23:0]};
    assign lastWord = ((32'(wordIdx) + 32'd1) == len_q);

    boot_word_packer #(
        .DATA_LEN    (DATA_LEN),
        .ADDR_LEN    (ADDR_LEN),
        .FETCH_WIDTH (FETCH_WIDTH),
        .IMEM_AW     (IMEM_AW)
    ) u_packer (
        .clk          (clk),
        .reset_x      (reset_x),
        .byte_valid_i (dataByte),
        .byte_i       (bus.rx_data),
        .last_word_i  (lastWord),
        .word_done_o  (wordDone),
        .slot_full_o  (slotFull),
        .word_idx_o   (wordIdx),
        .word_valid_o (wordValid),
        .word_o       (wordData),
        .word_addr_o  (wordAddr),
        .line_valid_o (lineValid),
        .line_o       (lineData),
        .line_addr_o  (lineAddr)
    );

    // Load sequencer with registered outputs. rx_ready is computed from the
    // next state so the byte completing the image or header is the last one
    // taken. A last word that fills its line goes straight to HOLD; a
    // partial line spends one FLUSH cycle while the packer's zero-padded
    // line write is on the bus.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state_q       <= ST_HDR;
            hdrCnt_q      <= 2'd0;
            len_q         <= '0;
            holdCnt_q     <= '0;
            rxReady_q     <= 1'b0;
            coreReset_q   <= 1'b1;
            progLoading_q <= 1'b1;
            loadDone_q    <= 1'b0;
            loadErr_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_HDR: begin
                    rxReady_q <= 1'b1;
                    if (accept) begin
                        hdrCnt_q <= hdrCnt_q + 2'd1;
                        case (hdrCnt_q)
                            2'd0: len_q[7:0]   <= bus.rx_data;
                            2'd1: len_q[15:8]  <= bus.rx_data;
                            2'd2: len_q[23:16] <= bus.rx_data;
                            default: begin
                                len_q <= hdrLen;
                                if (hdrLen > 32'(MAX_WORDS)) begin
                                    state_q   <= ST_ERR;
                                    rxReady_q <= 1'b0;
                                    loadErr_q <= 1'b1;
                                end else if (hdrLen == 32'd0) begin
                                    state_q    <= ST_HOLD;
                                    rxReady_q  <= 1'b0;
                                    loadDone_q <= 1'b1;
                                    holdCnt_q  <= '0;
                                end else begin
                                    state_q <= ST_DATA;
                                end
                            end
                        endcase
                    end
                end
                ST_DATA: begin
                    rxReady_q <= 1'b1;
                    if (wordDone && lastWord) begin
                        rxReady_q <= 1'b0;
                        if (slotFull) begin
                            state_q    <= ST_HOLD;
                            loadDone_q <= 1'b1;
                            holdCnt_q  <= '0;
                        end else begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q    <= ST_HOLD;
                    loadDone_q <= 1'b1;
                    holdCnt_q  <= '0;
                end
                ST_HOLD: begin
                    if (holdCnt_q == 16'(HOLD_CYCLES - 1)) begin
                        state_q       <= ST_RUN;
                        coreReset_q   <= 1'b0;
                        progLoading_q <= 1'b0;
                    end else begin
                        holdCnt_q <= holdCnt_q + 16'd1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_HDR;
                end
            endcase
        end
    end

    // Memory port ownership: the loader while loading, the core afterwards.
    // Core stores are blocked for the whole load phase.
    always_comb begin
        if (progLoading_q) begin
            bus.dmem_we    = wordValid;
            bus.dmem_addr  = wordAddr;
            bus.dmem_wdata = wordData;
            bus.imem_we    = lineValid;
            bus.imem_addr  = lineAddr;
        end else begin
            bus.dmem_we    = bus.core_dmem_we;
            bus.dmem_addr  = bus.core_dmem_addr;
            bus.dmem_wdata = bus.core_dmem_wdata;
            bus.imem_we    = 1'b0;
            bus.imem_addr  = bus.core_pc[IMEM_AW+LB-1 -: IMEM_AW];
        end
    end

    // Only a slice of the PC selects the line; the rest is deliberately dropped.
    assign unusedPc = ^bus.core_pc;

    assign bus.imem_wdata   = lineData;
    assign bus.rx_ready     = rxReady_q;
    assign bus.core_reset   = coreReset_q;
    assign bus.prog_loading = progLoading_q;
    assign bus.load_done    = loadDone_q;
    assign bus.load_err     = loadErr_q;

endmodule
